// File: rtl/arbiter2_rr_if.sv
// Request/grant bundle between requesters and the two-way round-robin arbiter.
// The master side drives requests and done; the slave side is the arbiter itself.
interface arbiter2_rr_if;
   logic req0;
   logic req1;
   logic done;
   logic gnt0;
   logic gnt1;
   logic busy;
   logic last;
   logic timeout;

   modport master (
      output req0, req1, done,
      input  gnt0, gnt1, busy, last, timeout
   );

   modport slave (
      input  req0, req1, done,
      output gnt0, gnt1, busy, last, timeout
   );
endinterface

// File: rtl/arbiter2_rr.sv
// Two-requester round-robin arbiter with a hold-time limit that forces release.
// Grant lines are a decoded registered index gated by the busy state.
module decoder1to2 (
   input  logic       sel,
   output logic [1:0] y
);
   always_comb begin
      y = 2'b00;
      y[sel] = 1'b1;
   end
endmodule

module arbiter2_rr #(
   parameter int unsigned HOLD_MAX = 4,
   parameter int unsigned CNT_W    = 3
) (
   input  logic          clk,
   input  logic          rst,
   arbiter2_rr_if.slave  bus
);
   localparam logic [CNT_W-1:0] CntMax = CNT_W'(HOLD_MAX - 1);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e           state_q;
   logic             idx_q;
   logic [CNT_W-1:0] cnt_q;
   logic             last_q;
   logic             timeout_q;

   logic             winner;
   logic             holder_req;
   logic             busy;
   logic [1:0]       dec;

   // A tie goes to whoever did not win last; a lone request wins outright.
   always_comb begin
      winner     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
      holder_req = idx_q ? bus.req1 : bus.req0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         idx_q     <= 1'b0;
         cnt_q     <= '0;
         last_q    <= 1'b1;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.req0 || bus.req1) begin
                  idx_q   <= winner;
                  last_q  <= winner;
                  cnt_q   <= '0;
                  state_q <= StGrant;
               end
            end
            StGrant: begin
               // done beats the hold limit, so a coincident done never flags timeout.
               if (bus.done || !holder_req) begin
                  state_q <= StIdle;
               end else if (cnt_q == CntMax) begin
                  state_q   <= StIdle;
                  timeout_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy = (state_q == StGrant);

   decoder1to2 u_dec (
      .sel (idx_q),
      .y   (dec)
   );

   assign bus.gnt0    = dec[0] & busy;
   assign bus.gnt1    = dec[1] & busy;
   assign bus.busy    = busy;
   assign bus.last    = last_q;
   assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_arbiter2_rr.sv
// Directed bench for arbiter2_rr with HOLD_MAX = 4; observed vector is
// {gnt1, gnt0, busy, last, timeout}.
module tb_arbiter2_rr;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   arbiter2_rr_if bus ();

   arbiter2_rr #(
      .HOLD_MAX (4),
      .CNT_W    (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [4:0] exp);
      logic [4:0] obs;
      obs = {bus.gnt1, bus.gnt0, bus.busy, bus.last, bus.timeout};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step_chk(input string tag, input logic [4:0] exp, input int n);
      for (int i = 0; i < n; i++) begin
         step();
         chk(tag, exp);
      end
   endtask

   initial begin
      rst      = 1'b1;
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      bus.done = 1'b0;

      // Reset with both requesting
      step_chk("reset", 5'b00010, 2);
      rst = 1'b0;

      // Contention: 4 x gnt0, idle+timeout, 4 x gnt1, idle+timeout, 4 x gnt0
      step_chk("rr_gnt0_a",   5'b01100, 4);
      step_chk("rr_idle_a",   5'b00001, 1);
      step_chk("rr_gnt1",     5'b10110, 4);
      step_chk("rr_idle_b",   5'b00011, 1);
      step_chk("rr_gnt0_b",   5'b01100, 4);
      step_chk("rr_idle_c",   5'b00001, 1);

      // done on the limit cycle wins: no timeout
      step_chk("coll_gnt1",   5'b10110, 4);
      bus.done = 1'b1;
      step_chk("coll_rel",    5'b00010, 1);
      bus.done = 1'b0;

      // Holder drops request in its 2nd grant cycle
      step_chk("drop_gnt0",   5'b01100, 2);
      bus.req0 = 1'b0;
      step_chk("drop_idle",   5'b00000, 1);
      step_chk("drop_gnt1",   5'b10110, 1);

      // Reset during 3rd gnt1 cycle
      step_chk("mid_gnt1",    5'b10110, 2);
      rst      = 1'b1;
      bus.req0 = 1'b1;
      step_chk("mid_rst",     5'b00010, 1);
      total++;
      assert (dut.cnt_q === 3'd0) else begin
         bad++;
         $error("FAIL mid_rst_cnt: observed %0d expected 0", dut.cnt_q);
      end
      rst = 1'b0;
      step_chk("mid_regrant", 5'b01100, 1);

      // Single requester 1 with done on the 2nd grant cycle
      bus.req0 = 1'b0;
      step_chk("single_rel0", 5'b00000, 1);
      step_chk("single_gnt",  5'b10110, 2);
      bus.done = 1'b1;
      step_chk("single_done", 5'b00010, 1);
      bus.done = 1'b0;
      step_chk("single_again", 5'b10110, 1);

      // done in IDLE is ignored
      bus.req1 = 1'b0;
      step_chk("idle_rel",    5'b00010, 1);
      step_chk("idle_stay",   5'b00010, 1);
      bus.done = 1'b1;
      bus.req0 = 1'b1;
      step_chk("idle_done",   5'b01100, 1);
      step_chk("grant_done",  5'b00000, 1);
      bus.done = 1'b0;
      bus.req0 = 1'b0;
      step_chk("quiet",       5'b00000, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/arbiter2_rr.md
# arbiter2_rr

Two-requester round-robin arbiter that shares a single resource between requester 0 and requester 1. A registered 1-bit grant index drives a `decoder1to2` instance, gated by the busy state, to produce the one-hot grant lines. A hold-time limit forces release so that neither requester can monopolise the resource. The block sits in front of any shared datapath whose select is decoded from a 1-bit index.

## Interface
- `HOLD_MAX`, 4: maximum consecutive cycles one grant may be held; legal range ≥ 1.
- `CNT_W`, 3: width of the hold counter; must satisfy 2^CNT_W ≥ HOLD_MAX.

- `clk`  in  1  clock; everything updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req0`  in  1  request from requester 0; held high while access is wanted.
- `req1`  in  1  request from requester 1.
- `done`  in  1  current holder releases the resource; sampled only in GRANT.
- `gnt0`  out  1  grant to requester 0.
- `gnt1`  out  1  grant to requester 1; `{gnt1,gnt0}` is one-hot or 00.
- `busy`  out  1  high while in GRANT.
- `last`  out  1  index of the most recent winner.
- `timeout`  out  1  one-cycle pulse after a forced release.

## Operation
- There are two states: IDLE and GRANT. Registers are `state`, `idx`, `cnt`, `last` and `timeout`.
- `{gnt1,gnt0}` is the `decoder1to2` output for `idx`, ANDed with `busy`. It depends only on registers, so there is no combinational input→output path.

- **IDLE** arbitration, evaluated at each edge:
  - No request: stay in IDLE.
  - Exactly one request: grant that requester, whatever `last` holds.
  - Both requests: grant `~last`.
  - On a grant: `idx` and `last` take the winner, `cnt` is cleared to 0, and the block moves to GRANT.

- **GRANT**, evaluated at each edge:
  - If `done` = 1, or the holder's request is low: release to IDLE with `timeout` = 0.
  - Else if `cnt` = HOLD_MAX−1: forced release to IDLE; `timeout` is 1 for the following IDLE cycle.
  - Otherwise: `cnt` increments and the block stays in GRANT.

- **Boundary cases**:
  - `done` in the same cycle as the limit: `done` wins and `timeout` stays 0.
  - The non-holder's request has no effect during GRANT.
  - `done` asserted in IDLE is ignored.
  - HOLD_MAX = 1: every grant lasts exactly one cycle, and a forced release is flagged unless `done` is high.

- **Reset values**: state = IDLE, `gnt0` = `gnt1` = 0, `busy` = 0, `idx` = 0, `cnt` = 0, `timeout` = 0, `last` = 1. Because `last` resets to 1, requester 0 wins the first tie.
- **Reset mid-grant**: outputs take their reset values at the next edge, with no timeout pulse.

## Timing
- Request-to-grant latency:
  - A request sampled in IDLE at edge E gives a grant visible from E (after the clock-to-q delay) onward.
  - Grant is asserted in the first cycle after the sampling edge.
- Release:
  - A release sampled at edge E drops the grant after E.
  - There is at least one IDLE cycle with `{gnt1,gnt0}` = 00 between any two grants.
  - The earliest re-grant is at edge E+1.
- Maximum grant length is HOLD_MAX cycles.
- Under continuous contention with no `done`, the grant pattern is HOLD_MAX cycles on requester 0, 1 idle cycle, HOLD_MAX cycles on requester 1, 1 idle cycle, and so on.
- `timeout` is high for exactly the one IDLE cycle after a forced release.
- `busy` equals `gnt0 | gnt1` in every cycle.

## Test plan
- **Reset**: `rst` = 1 for 2 cycles with `req0` = `req1` = 1, then release reset.
  - During reset: `gnt` = 00, `busy` = 0, `last` = 1, `timeout` = 0.
  - First grant after reset: `gnt0` = 1.
- **Single requester**: `req1` = 1 only, `done` pulsed on the 2nd grant cycle.
  - `gnt1` is high for 2 cycles, then 00 for 1 cycle, then `gnt1` again while `req1` stays high.
- **Contention round-robin**: `req0` = `req1` = 1 continuously, `done` = 0, HOLD_MAX = 4.
  - Pattern: `gnt0` ×4, 00, `gnt1` ×4, 00, `gnt0` ×4.
  - `timeout` pulses in each 00 cycle.
  - `last` toggles 0→1→0.
- **done vs limit collision**: `done` = 1 in the 4th GRANT cycle (`cnt` = 3).
  - Release to IDLE with `timeout` = 0.
- **Holder drops request**: `req0` falls in the 2nd grant cycle while `req1` = 1.
  - `gnt` = 00 for 1 cycle, then `gnt1` = 1; no timeout.
- **Reset mid-grant**: `rst` pulsed during the 3rd cycle of `gnt1`.
  - Next cycle: `gnt` = 00, `busy` = 0, `last` = 1, `cnt` = 0.
  - With both requesting after reset: `gnt0` wins.
